lsq_param: RTL and testbench
============================

LSQ_PARAM -- requirements
Module: lsq_param

Interface
REQ-001 Parameters: DEPTH (default 16, power of 2, >=4, entry count); TAG_W (default 4, ROB tag width); N_CDB (default 2, broadcast channels).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 rdy  in  1  global enable; low freezes all state.
REQ-005 clear  in  1  pipeline flush from ROB misprediction.
REQ-006 disp_valid  in  1; disp_op  in  6 (op[5:3]=101 load, 111 store); disp_rob_tag  in  TAG_W.
REQ-007 disp_vj, disp_vk, disp_imm  in  32 each; disp_qj, disp_qk  in  TAG_W+1 (value 2**TAG_W = READY).
REQ-008 full  out  1  count==DEPTH; count  out  $clog2(DEPTH)+1  occupancy.
REQ-009 mem_req  out  1; mem_addr, mem_val  out  32; mem_op  out  6; mem_done  in  1.
REQ-010 rob_head  in  TAG_W; rob_commit_valid  in  1; rob_commit_tag  in  TAG_W.
REQ-011 cdb_valid  in  N_CDB; cdb_tag  in  N_CDB*TAG_W; cdb_val  in  N_CDB*32 (channel k at slice k).

Function
REQ-012 Circular FIFO, head/tail pointers $clog2(DEPTH) bits wrapping modulo DEPTH; separate count register.
REQ-013 Dispatch when disp_valid && !full: write entry at tail, tail+1, count+1; dispatch while full ignored (bench asserts never).
REQ-014 Same-cycle bypass: a dispatched qj/qk matching a valid CDB tag that cycle is stored READY with that CDB value.
REQ-015 Wake-up: each busy entry with qj==cdb_tag[k] sets qj READY, vj<=cdb_val[k]; same for qk/vk; lowest k wins on duplicate tags.
REQ-016 Address = vj + disp_imm, 32-bit wrap, computed at issue.
REQ-017 Commit: rob_commit_valid marks matching uncommitted busy store committed; last_commit index updated.
REQ-018 Issue: head busy, qj/qk READY, no request in flight, and (store committed) or (load and (addr[17:16]!=2'b11 or rob_head==entry tag)); mem_req rises next cycle.
REQ-019 Issue payload: mem_addr=address; mem_op=op; mem_val = vk (store) or rob tag zero-extended (load).
REQ-020 mem_req, mem_addr, mem_val, mem_op held stable until mem_done; mem_done cycle: mem_req<=0, head+1, count-1, entry freed; no issue same cycle.
REQ-021 Simultaneous dispatch and retire: count unchanged; at count==DEPTH retire frees, dispatch still blocked that cycle.
REQ-022 clear priority over dispatch (dispatch dropped); CDB/commit ignored that cycle.
REQ-023 On clear: uncommitted entries freed; tail <= last_commit+1 if committed stores exist, else head+1 if request in flight, else head; count recomputed; mem_done same cycle retires head too.
REQ-024 In-flight request at clear continues until mem_done; if no committed stores remain afterwards, queue becomes empty.
REQ-025 rdy low: no state change, outputs hold.

Reset
REQ-026 rst low: head=tail=0, count=0, all busy/committed=0, q fields READY, mem_req=0, mem_addr=mem_val=0, mem_op=0, last_commit=none; takes effect immediately, including mid-request.

Structure
REQ-027 Package lsq_pkg: op-class codes (LOAD 3'b101, STORE 3'b111), READY tag function of TAG_W, IO region bits 2'b11 at [17:16].
REQ-028 One sub-module lsq_cdb_match: N_CDB-way tag compare returning hit and selected value, instanced per operand.

Verification
REQ-029 Reset mid-request: mem_req=1, rst low -> mem_req=0, count=0 same edge, no later mem_done effect.
REQ-030 Load tag 3 base 0x100 imm 4, READY -> mem_req next cycle, mem_addr=0x104, mem_val=3; mem_done -> count 0.
REQ-031 Store qk=5, CDB k=1 tag 5 val 0xDEAD same cycle as dispatch -> vk=0xDEAD; commit tag 5 -> mem_val=0xDEAD.
REQ-032 IO load addr 0x30000, rob_head!=tag -> no mem_req; rob_head=tag -> mem_req next cycle.
REQ-033 Fill DEPTH entries -> full=1, extra dispatch ignored; drain through wrap, head/tail wrap to 0, count returns 0.
REQ-034 2 committed + 3 uncommitted stores, clear -> count=2, tail=last_commit+1, committed stores still issue in order.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared encodings for the load/store queue: op classes, IO address region and
// the READY tag value.
package lsq_pkg;
  localparam logic [2:0] OPC_LOAD  = 3'b101;
  localparam logic [2:0] OPC_STORE = 3'b111;
  localparam logic [1:0] IO_REGION = 2'b11;
  localparam int         IO_LSB    = 16;

  // A q field equal to 2**tag_w means "operand value already captured".
  function automatic int ready_tag(input int tag_w);
    return 1 << tag_w;
  endfunction
endpackage

// File: rtl/lsq_param_if.sv
// Dispatch / memory / ROB / CDB bundle of the load/store queue.
// The master side is the pipeline around the queue, the slave side is the queue.
interface lsq_param_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int N_CDB = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  disp_valid;
  logic [5:0]            disp_op;
  logic [TAG_W-1:0]      disp_rob_tag;
  logic [31:0]           disp_vj, disp_vk, disp_imm;
  logic [TAG_W:0]        disp_qj, disp_qk;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  mem_req;
  logic [31:0]           mem_addr, mem_val;
  logic [5:0]            mem_op;
  logic                  mem_done;
  logic [TAG_W-1:0]      rob_head;
  logic                  rob_commit_valid;
  logic [TAG_W-1:0]      rob_commit_tag;
  logic [N_CDB-1:0]      cdb_valid;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*32-1:0]   cdb_val;

  modport master (
    output disp_valid, disp_op, disp_rob_tag, disp_vj, disp_vk, disp_imm, disp_qj, disp_qk,
    output mem_done, rob_head, rob_commit_valid, rob_commit_tag, cdb_valid, cdb_tag, cdb_val,
    input  full, count, mem_req, mem_addr, mem_val, mem_op
  );
  modport slave (
    input  disp_valid, disp_op, disp_rob_tag, disp_vj, disp_vk, disp_imm, disp_qj, disp_qk,
    input  mem_done, rob_head, rob_commit_valid, rob_commit_tag, cdb_valid, cdb_tag, cdb_val,
    output full, count, mem_req, mem_addr, mem_val, mem_op
  );
endinterface

// File: rtl/lsq_cdb_match.sv
// N_CDB-way tag compare for one operand; the lowest channel wins on duplicates.
module lsq_cdb_match #(
  parameter int TAG_W = 4,
  parameter int N_CDB = 2
) (
  input  logic [TAG_W:0]         i_q,
  input  logic [N_CDB-1:0]       i_cdb_valid,
  input  logic [N_CDB*TAG_W-1:0] i_cdb_tag,
  input  logic [N_CDB*32-1:0]    i_cdb_val,
  output logic                   o_hit,
  output logic [31:0]            o_val
);
  // Scan high to low so the lowest matching channel is the last to write.
  always_comb begin
    o_hit = 1'b0;
    o_val = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (i_cdb_valid[k] && i_q == {1'b0, i_cdb_tag[k*TAG_W +: TAG_W]}) begin
        o_hit = 1'b1;
        o_val = i_cdb_val[k*32 +: 32];
      end
    end
  end
endmodule

// File: rtl/lsq_param.sv
// In-order load/store queue: circular buffer with CDB wake-up, store commit,
// single outstanding memory request and misprediction flush.
module lsq_param
  import lsq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4,
  parameter int N_CDB = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       clear,
  lsq_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = TAG_W + 1;
  localparam logic [QW-1:0] READY = QW'(ready_tag(TAG_W));

  logic [DEPTH-1:0]             r_busy, r_comm;
  logic [DEPTH-1:0][5:0]        r_op;
  logic [DEPTH-1:0][TAG_W-1:0]  r_tag;
  logic [DEPTH-1:0][QW-1:0]     r_qj, r_qk;
  logic [DEPTH-1:0][31:0]       r_vj, r_vk, r_imm;
  logic [AW-1:0]                r_head, r_tail, r_lc;
  logic                         r_lc_vld;
  logic [CW-1:0]                r_count;
  logic                         r_mem_req;
  logic [31:0]                  r_mem_addr, r_mem_val;
  logic [5:0]                   r_mem_op;

  logic [DEPTH-1:0]             w_hj, w_hk, w_keep;
  logic [DEPTH-1:0][31:0]       w_cj, w_ck;
  logic                         w_dhj, w_dhk;
  logic [31:0]                  w_dcj, w_dck, w_addr;
  logic [2:0]                   w_hcls;
  logic                         w_full, w_retire, w_disp, w_issue, w_any_comm;
  logic [AW-1:0]                w_clr_tail;
  logic [CW-1:0]                w_keep_cnt;

  lsq_cdb_match #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_dj (
    .i_q(bus.disp_qj), .i_cdb_valid(bus.cdb_valid), .i_cdb_tag(bus.cdb_tag),
    .i_cdb_val(bus.cdb_val), .o_hit(w_dhj), .o_val(w_dcj));
  lsq_cdb_match #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_dk (
    .i_q(bus.disp_qk), .i_cdb_valid(bus.cdb_valid), .i_cdb_tag(bus.cdb_tag),
    .i_cdb_val(bus.cdb_val), .o_hit(w_dhk), .o_val(w_dck));

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    lsq_cdb_match #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_mj (
      .i_q(r_qj[e]), .i_cdb_valid(bus.cdb_valid), .i_cdb_tag(bus.cdb_tag),
      .i_cdb_val(bus.cdb_val), .o_hit(w_hj[e]), .o_val(w_cj[e]));
    lsq_cdb_match #(.TAG_W(TAG_W), .N_CDB(N_CDB)) u_mk (
      .i_q(r_qk[e]), .i_cdb_valid(bus.cdb_valid), .i_cdb_tag(bus.cdb_tag),
      .i_cdb_val(bus.cdb_val), .o_hit(w_hk[e]), .o_val(w_ck[e]));
  end

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_retire = r_mem_req && bus.mem_done;
  assign w_disp   = bus.disp_valid && !w_full && !clear;
  assign w_addr   = r_vj[r_head] + r_imm[r_head];
  assign w_hcls   = r_op[r_head][5:3];
  // IO-region loads are non-speculative: they wait until they are the ROB head.
  assign w_issue  = !clear && !r_mem_req && r_busy[r_head] &&
                    r_qj[r_head] == READY && r_qk[r_head] == READY &&
                    ((w_hcls == OPC_STORE && r_comm[r_head]) ||
                     (w_hcls == OPC_LOAD && (w_addr[IO_LSB +: 2] != IO_REGION ||
                                             bus.rob_head == r_tag[r_head])));

  // Flush survivors: committed stores plus an in-flight head not retiring now.
  always_comb begin
    w_keep = r_busy & r_comm;
    if (r_mem_req) w_keep[r_head] = r_busy[r_head] && !bus.mem_done;
    w_keep_cnt = '0;
    for (int e = 0; e < DEPTH; e++) w_keep_cnt = w_keep_cnt + CW'(w_keep[e]);
    w_any_comm = |(w_keep & r_comm);
    if (w_any_comm && r_lc_vld) w_clr_tail = r_lc + 1'b1;
    else if (r_mem_req)         w_clr_tail = r_head + 1'b1;
    else                        w_clr_tail = r_head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0; r_comm <= '0; r_op <= '0; r_tag <= '0;
      r_qj <= {DEPTH{READY}}; r_qk <= {DEPTH{READY}};
      r_vj <= '0; r_vk <= '0; r_imm <= '0;
      r_head <= '0; r_tail <= '0; r_lc <= '0; r_lc_vld <= 1'b0; r_count <= '0;
      r_mem_req <= 1'b0; r_mem_addr <= '0; r_mem_val <= '0; r_mem_op <= '0;
    end else if (rdy) begin
      if (w_retire) begin
        r_mem_req      <= 1'b0;
        r_busy[r_head] <= 1'b0;
        r_comm[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      if (clear) begin
        r_busy  <= w_keep;
        r_comm  <= r_comm & w_keep;
        r_tail  <= w_clr_tail;
        r_count <= w_keep_cnt;
        if (!w_any_comm) r_lc_vld <= 1'b0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (r_busy[e] && w_hj[e]) begin r_qj[e] <= READY; r_vj[e] <= w_cj[e]; end
          if (r_busy[e] && w_hk[e]) begin r_qk[e] <= READY; r_vk[e] <= w_ck[e]; end
          if (bus.rob_commit_valid && r_busy[e] && !r_comm[e] &&
              r_op[e][5:3] == OPC_STORE && r_tag[e] == bus.rob_commit_tag) begin
            r_comm[e] <= 1'b1;
            r_lc      <= AW'(e);
            r_lc_vld  <= 1'b1;
          end
        end
        if (w_disp) begin
          r_busy[r_tail] <= 1'b1;
          r_comm[r_tail] <= 1'b0;
          r_op[r_tail]   <= bus.disp_op;
          r_tag[r_tail]  <= bus.disp_rob_tag;
          r_imm[r_tail]  <= bus.disp_imm;
          r_qj[r_tail]   <= w_dhj ? READY : bus.disp_qj;
          r_vj[r_tail]   <= w_dhj ? w_dcj : bus.disp_vj;
          r_qk[r_tail]   <= w_dhk ? READY : bus.disp_qk;
          r_vk[r_tail]   <= w_dhk ? w_dck : bus.disp_vk;
          r_tail         <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_disp) - CW'(w_retire);
        if (w_issue) begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_addr;
          r_mem_op   <= r_op[r_head];
          r_mem_val  <= (w_hcls == OPC_STORE) ? r_vk[r_head] : 32'(r_tag[r_head]);
        end
      end
    end
  end

  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_val  = r_mem_val;
  assign bus.mem_op   = r_mem_op;
endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: a queue-based model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_lsq_param;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int N_CDB = 2;
  localparam logic [4:0] RDY = 5'd16;
  localparam logic [5:0] LD  = 6'h28;
  localparam logic [5:0] ST  = 6'h38;

  logic clk = 1'b0;
  logic rst, rdy, clear;
  int   n_vec = 0;
  int   n_err = 0;

  lsq_param_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .N_CDB(N_CDB)) ifc ();
  lsq_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .N_CDB(N_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [4:0]  qj, qk;
    logic [31:0] vj, vk, imm;
    bit          comm;
  } ent_t;

  ent_t        q[$];
  logic        m_req;
  logic [31:0] m_addr, m_val;
  logic [5:0]  m_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void cdb_look(input logic [4:0] qv, output bit hit, output logic [31:0] v);
    hit = 1'b0;
    v   = '0;
    for (int k = 0; k < N_CDB; k++)
      if (!hit && ifc.cdb_valid[k] && qv == {1'b0, ifc.cdb_tag[k*TAG_W +: TAG_W]}) begin
        hit = 1'b1;
        v   = ifc.cdb_val[k*32 +: 32];
      end
  endfunction

  function automatic bit may_issue(input ent_t e);
    logic [31:0] a;
    a = e.vj + e.imm;
    if (e.qj != RDY || e.qk != RDY) return 1'b0;
    if (e.op[5:3] == 3'b111) return e.comm;
    if (e.op[5:3] == 3'b101) return (a[17:16] != 2'b11) || (ifc.rob_head == e.tag);
    return 1'b0;
  endfunction

  // Model: the queue holds live entries oldest first.
  always @(posedge clk or negedge rst) begin : model
    ent_t h, n, e;
    bit ret, iss, hit, dsp;
    logic [31:0] v;
    int sz;
    if (!rst) begin
      q.delete();
      m_req = 1'b0; m_addr = '0; m_val = '0; m_op = '0;
    end else if (rdy) begin
      ret = m_req && ifc.mem_done;
      sz  = q.size();
      if (clear) begin
        if (ret) begin void'(q.pop_front()); m_req = 1'b0; end
        for (int i = q.size() - 1; i >= 0; i--)
          if (!q[i].comm && !(i == 0 && m_req)) q.delete(i);
      end else begin
        iss = 1'b0;
        if (!m_req && sz > 0) begin h = q[0]; iss = may_issue(h); end
        for (int i = 0; i < sz; i++) begin
          e = q[i];
          cdb_look(e.qj, hit, v); if (hit) begin e.qj = RDY; e.vj = v; end
          cdb_look(e.qk, hit, v); if (hit) begin e.qk = RDY; e.vk = v; end
          if (ifc.rob_commit_valid && e.op[5:3] == 3'b111 && e.tag == ifc.rob_commit_tag)
            e.comm = 1'b1;
          q[i] = e;
        end
        dsp = ifc.disp_valid && sz < DEPTH;
        n.op = ifc.disp_op; n.tag = ifc.disp_rob_tag; n.imm = ifc.disp_imm; n.comm = 1'b0;
        cdb_look(ifc.disp_qj, hit, v);
        n.qj = hit ? RDY : ifc.disp_qj; n.vj = hit ? v : ifc.disp_vj;
        cdb_look(ifc.disp_qk, hit, v);
        n.qk = hit ? RDY : ifc.disp_qk; n.vk = hit ? v : ifc.disp_vk;
        if (ret) begin void'(q.pop_front()); m_req = 1'b0; end
        if (dsp) q.push_back(n);
        if (iss) begin
          m_req  = 1'b1;
          m_addr = h.vj + h.imm;
          m_op   = h.op;
          m_val  = (h.op[5:3] == 3'b111) ? h.vk : {28'b0, h.tag};
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("count",    32'(ifc.count),    32'(q.size()));
    chk("full",     32'(ifc.full),     32'(q.size() == DEPTH));
    chk("mem_req",  32'(ifc.mem_req),  32'(m_req));
    chk("mem_addr", ifc.mem_addr,      m_addr);
    chk("mem_val",  ifc.mem_val,       m_val);
    chk("mem_op",   32'(ifc.mem_op),   32'(m_op));
  end

  task automatic idle();
    ifc.disp_valid = 1'b0; ifc.disp_op = '0; ifc.disp_rob_tag = '0;
    ifc.disp_vj = '0; ifc.disp_vk = '0; ifc.disp_imm = '0;
    ifc.disp_qj = RDY; ifc.disp_qk = RDY;
    ifc.mem_done = 1'b0; ifc.rob_commit_valid = 1'b0; ifc.rob_commit_tag = '0;
    ifc.cdb_valid = '0; ifc.cdb_tag = '0; ifc.cdb_val = '0;
    clear = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [31:0] imm,
                      input logic [4:0] qj, input logic [4:0] qk);
    ifc.disp_valid = 1'b1; ifc.disp_op = op; ifc.disp_rob_tag = tag;
    ifc.disp_vj = vj; ifc.disp_vk = vk; ifc.disp_imm = imm; ifc.disp_qj = qj; ifc.disp_qk = qk;
    @(negedge clk);
    ifc.disp_valid = 1'b0; ifc.disp_qj = RDY; ifc.disp_qk = RDY;
  endtask

  task automatic commit(input logic [3:0] tag);
    ifc.rob_commit_valid = 1'b1; ifc.rob_commit_tag = tag;
    @(negedge clk);
    ifc.rob_commit_valid = 1'b0;
  endtask

  task automatic done();
    ifc.mem_done = 1'b1;
    @(negedge clk);
    ifc.mem_done = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int i;
    i = 0;
    while (!ifc.mem_req && i < 20) begin @(negedge clk); i++; end
    chk(nm, 32'(ifc.mem_req), 32'd1);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    idle(); ifc.rob_head = '0;
    tick(3);
    chk("reset_count", 32'(ifc.count), 32'd0);
    chk("reset_req",   32'(ifc.mem_req), 32'd0);
    chk("reset_addr",  ifc.mem_addr, 32'd0);
    rst = 1'b1;
    tick(1);

    // Plain load, READY operands
    disp(LD, 4'd3, 32'h100, 32'h0, 32'h4, RDY, RDY);
    chk("ld_count", 32'(ifc.count), 32'd1);
    wait_req("ld_req");
    chk("ld_addr", ifc.mem_addr, 32'h104);
    chk("ld_val",  ifc.mem_val,  32'd3);
    chk("ld_op",   32'(ifc.mem_op), 32'(LD));
    done();
    chk("ld_empty", 32'(ifc.count), 32'd0);

    // Store with same-cycle CDB bypass on channel 1
    ifc.cdb_valid = 2'b10; ifc.cdb_tag = {4'd5, 4'd0}; ifc.cdb_val = {32'hDEAD, 32'h0};
    disp(ST, 4'd5, 32'h200, 32'h0, 32'h8, RDY, 5'd5);
    ifc.cdb_valid = '0;
    tick(2);
    chk("st_wait_commit", 32'(ifc.mem_req), 32'd0);
    commit(4'd5);
    wait_req("st_req");
    chk("st_val",  ifc.mem_val,  32'hDEAD);
    chk("st_addr", ifc.mem_addr, 32'h208);
    done();

    // Wake-up with duplicate tags on both channels: channel 0 wins
    disp(ST, 4'd6, 32'h300, 32'h0, 32'h0, RDY, 5'd9);
    ifc.cdb_valid = 2'b11; ifc.cdb_tag = {4'd9, 4'd9}; ifc.cdb_val = {32'h22, 32'h11};
    tick(1);
    ifc.cdb_valid = '0;
    commit(4'd6);
    wait_req("dup_req");
    chk("dup_val", ifc.mem_val, 32'h11);
    done();

    // IO-region load waits for ROB head
    disp(LD, 4'd7, 32'h30000, 32'h0, 32'h0, RDY, RDY);
    tick(3);
    chk("io_hold", 32'(ifc.mem_req), 32'd0);
    ifc.rob_head = 4'd7;
    tick(1);
    chk("io_req",  32'(ifc.mem_req), 32'd1);
    chk("io_addr", ifc.mem_addr, 32'h30000);
    chk("io_val",  ifc.mem_val,  32'd7);
    done();
    ifc.rob_head = '0;

    // rdy low freezes dispatch and retire
    rdy = 1'b0;
    disp(ST, 4'd1, 32'h0, 32'h0, 32'h0, RDY, RDY);
    chk("rdy_disp", 32'(ifc.count), 32'd0);
    rdy = 1'b1;
    disp(LD, 4'd8, 32'h60, 32'h0, 32'h0, RDY, RDY);
    wait_req("rdy_req");
    rdy = 1'b0; ifc.mem_done = 1'b1;
    tick(2);
    chk("rdy_hold_req", 32'(ifc.mem_req), 32'd1);
    chk("rdy_hold_cnt", 32'(ifc.count), 32'd1);
    ifc.mem_done = 1'b0; rdy = 1'b1;
    done();
    chk("rdy_done", 32'(ifc.count), 32'd0);

    // Fill, overflow attempt, retire+dispatch at full, drain through wrap
    for (int i = 0; i < DEPTH; i++)
      disp(ST, 4'(i), 32'h1000 + 32'(i) * 16, 32'(i), 32'h0, RDY, RDY);
    chk("fill_full",  32'(ifc.full),  32'd1);
    chk("fill_count", 32'(ifc.count), 32'd16);
    disp(ST, 4'd10, 32'h9999, 32'h0, 32'h0, RDY, RDY);
    chk("overflow_count", 32'(ifc.count), 32'd16);
    commit(4'd0);
    wait_req("fill_req0");
    chk("fill_addr0", ifc.mem_addr, 32'h1000);
    ifc.mem_done = 1'b1;
    disp(ST, 4'd0, 32'h2000, 32'h0, 32'h0, RDY, RDY);
    ifc.mem_done = 1'b0;
    chk("full_retire_cnt", 32'(ifc.count), 32'd15);
    disp(ST, 4'd0, 32'h2000, 32'h0, 32'h0, RDY, RDY);
    chk("refill_full", 32'(ifc.full), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      commit(4'(i));
      wait_req("drain_req");
      chk("drain_addr", ifc.mem_addr, 32'h1000 + 32'(i) * 16);
      done();
    end
    commit(4'd0);
    wait_req("wrap_req");
    chk("wrap_addr", ifc.mem_addr, 32'h2000);
    done();
    chk("drain_empty", 32'(ifc.count), 32'd0);

    // Clear with 2 committed + 3 uncommitted stores; dispatch during clear dropped
    disp(ST, 4'd1, 32'h0, 32'h11, 32'h40, 5'd9, RDY);
    for (int t = 2; t <= 5; t++)
      disp(ST, 4'(t), 32'h500 + 32'(t) * 4, 32'(t), 32'h0, RDY, RDY);
    commit(4'd1);
    commit(4'd2);
    clear = 1'b1;
    disp(ST, 4'd6, 32'h0, 32'h0, 32'h0, RDY, RDY);
    clear = 1'b0;
    chk("clr_count", 32'(ifc.count), 32'd2);
    ifc.cdb_valid = 2'b01; ifc.cdb_tag = {4'd0, 4'd9}; ifc.cdb_val = {32'h0, 32'h4000};
    tick(1);
    ifc.cdb_valid = '0;
    wait_req("clr_req1");
    chk("clr_addr1", ifc.mem_addr, 32'h4040);
    chk("clr_val1",  ifc.mem_val,  32'h11);
    done();
    wait_req("clr_req2");
    chk("clr_addr2", ifc.mem_addr, 32'h508);
    done();
    tick(3);
    chk("clr_no_more", 32'(ifc.mem_req), 32'd0);
    chk("clr_empty",   32'(ifc.count),   32'd0);

    // Clear with an in-flight load, then clear together with mem_done
    disp(LD, 4'd1, 32'h40, 32'h0, 32'h0, RDY, RDY);
    disp(ST, 4'd2, 32'h0, 32'h0, 32'h0, RDY, RDY);
    disp(ST, 4'd3, 32'h0, 32'h0, 32'h0, RDY, RDY);
    chk("fl_req", 32'(ifc.mem_req), 32'd1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("fl_count", 32'(ifc.count), 32'd1);
    done();
    chk("fl_empty", 32'(ifc.count), 32'd0);
    disp(LD, 4'd4, 32'h70, 32'h0, 32'h1, RDY, RDY);
    wait_req("fl2_req");
    chk("fl2_addr", ifc.mem_addr, 32'h71);
    clear = 1'b1; ifc.mem_done = 1'b1;
    tick(1);
    clear = 1'b0; ifc.mem_done = 1'b0;
    chk("fl2_empty", 32'(ifc.count), 32'd0);
    chk("fl2_req_lo", 32'(ifc.mem_req), 32'd0);

    // Reset in the middle of a request
    disp(LD, 4'd2, 32'h80, 32'h0, 32'h0, RDY, RDY);
    wait_req("rst_req");
    #2 rst = 1'b0;
    #1;
    chk("rst_req_lo", 32'(ifc.mem_req), 32'd0);
    chk("rst_count",  32'(ifc.count),   32'd0);
    tick(2);
    rst = 1'b1;
    done();
    chk("rst_after_done_cnt", 32'(ifc.count),   32'd0);
    chk("rst_after_done_req", 32'(ifc.mem_req), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
endmodule
